// File: rtl/mem_acc_pkg.sv
// Shared encodings for the memory access unit: access size codes and FSM states.
package mem_acc_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/mem_lane_fmt.sv
// Little-endian lane formatting: extracts/extends a load lane from a memory
// word and merges byte/half store data into a memory word.
module mem_lane_fmt
  import mem_acc_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane and build both the extended load value and the merged store word.
  always_comb begin
    byte_sel = word_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

    load_o = word_i;
    case (size_i)
      SZ_BYTE: load_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_o = {{16{sign_i & half_sel[15]}}, half_sel};
      default: load_o = word_i;
    endcase

    merge_o = word_i;
    case (size_i)
      SZ_BYTE: merge_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
      SZ_HALF: begin
        if (offset_i[1]) merge_o[31:16] = wdata_i[15:0];
        else             merge_o[15:0]  = wdata_i[15:0];
      end
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit in front of a word-wide memory with
// combinational read and falling-edge write. Byte/half stores use read-modify-write.
module mem_access_unit
  import mem_acc_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        req_err;
  logic        mem_we_raw;
  logic [31:0] fmt_load;
  logic [31:0] fmt_merge;

  mem_lane_fmt u_fmt (
    .word_i   (mem_rdata),
    .offset_i (addr_q[1:0]),
    .size_i   (size_q),
    .sign_i   (sign_q),
    .wdata_i  (wdata_q),
    .load_o   (fmt_load),
    .merge_o  (fmt_merge)
  );

  // Classify the incoming request: illegal size, misalignment, or word index past the memory.
  always_comb begin
    req_err = ({2'b00, req_addr[31:2]} >= MEM_WORDS_W);
    case (req_size)
      SZ_HALF: if (req_addr[0])        req_err = 1'b1;
      SZ_WORD: if (|req_addr[1:0])     req_err = 1'b1;
      SZ_ILL:                          req_err = 1'b1;
      default: ;
    endcase
  end

  // Next-state and output decode; memory bus is idle (zero) outside LOAD/READ/WRITE.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    sign_d     = sign_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    resp_err   = 1'b0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    mem_we_raw = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          sign_d  = req_sign;
          we_d    = req_we;
          wdata_d = req_wdata;
          rdata_d = 32'd0;
          err_d   = req_err;
          if (req_err)                state_d = RESP;
          else if (!req_we)           state_d = LOAD;
          else if (req_size == SZ_WORD) state_d = WRITE;
          else                        state_d = READ;
        end
      end
      LOAD: begin
        mem_addr = {addr_q[31:2], 2'b00};
        rdata_d  = fmt_load;
        state_d  = RESP;
      end
      READ: begin
        mem_addr = {addr_q[31:2], 2'b00};
        wdata_d  = fmt_merge;
        state_d  = WRITE;
      end
      WRITE: begin
        mem_addr   = {addr_q[31:2], 2'b00};
        mem_wdata  = wdata_q;
        mem_we_raw = 1'b1;
        state_d    = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = we_q ? 32'd0 : rdata_q;
        resp_err   = err_q;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset must also kill a write already on the bus before the falling edge.
  assign mem_we = mem_we_raw & ~reset;

  // State and request registers; reset clears everything so an aborted request leaves no trace.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      size_q  <= 2'd0;
      sign_q  <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver pushes model expectations,
// monitor pops and compares on each response handshake.
module tb_mem_access_unit;

  localparam int MW = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_sign;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_WORDS(MW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_sign   (req_sign),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  // External memory: combinational read, falling-edge write.
  logic [31:0] tb_mem [MW];
  logic        mem_init = 1'b0;

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  assign mem_rdata = (mem_addr[31:2] < MW) ? tb_mem[mem_addr[7:2]] : 32'hDEAD_BEEF;

  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < MW; i++) tb_mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else if (mem_we && (mem_addr[31:2] < MW)) begin
      tb_mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          writes;
    logic [31:0] waddr;
    logic [31:0] wword;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [MW];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s", name);
  endtask

  // Reference model: byte-addressed little-endian memory arithmetic.
  task automatic model(input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
    longint unsigned idx, off, nb, lanemask, mask, w, v;
    idx = 64'(addr) >> 2;
    off = 64'(addr) % 4;
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    e.rdata  = 32'd0;
    e.writes = 0;
    e.waddr  = 32'd0;
    e.wword  = 32'd0;
    e.err    = (size == 2'd3) || ((64'(addr) % nb) != 0) || (idx >= MW);
    lanemask = (64'd1 << (8 * nb)) - 1;
    if (e.err) begin
      e.lat = 1;
    end else if (!we) begin
      w = 64'(ref_mem[int'(idx)]);
      v = (w >> (8 * off)) & lanemask;
      if (sign && nb < 4 && ((v >> (8 * nb - 1)) & 1) == 1) v = v | ~lanemask;
      e.rdata = 32'(v);
      e.lat   = 2;
    end else begin
      mask = lanemask << (8 * off);
      w = (64'(ref_mem[int'(idx)]) & ~mask) | ((64'(wdata) << (8 * off)) & mask);
      ref_mem[int'(idx)] = 32'(w);
      e.writes = 1;
      e.waddr  = 32'(idx * 4);
      e.wword  = 32'(w);
      e.lat    = (nb == 4) ? 2 : 3;
    end
  endtask

  // Issue one request, wait for its response, hold resp_ready low for 'hold' cycles, then handshake.
  task automatic do_txn(input logic we, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                        input logic use_exp, input logic [31:0] exp_rd);
    exp_t e;
    int   k;
    model(we, size, sign, addr, wdata, e);
    if (use_exp) e.rdata = exp_rd;
    sb.push_back(e);
    req_we    = we;
    req_size  = size;
    req_sign  = sign;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 10) begin @(negedge clk); k++; end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    k = 0;
    while (!resp_valid && k < 10) begin @(negedge clk); #1; k++; end
    if (!resp_valid) begin
      fail("resp_timeout");
      sb.delete();
      return;
    end
    repeat (hold) @(negedge clk);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    check("idle_ready", 32'(req_ready), 32'd1);
    check("idle_no_resp", 32'(resp_valid), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: latency, write-bus contents, hold stability and final response values.
  int          ncyc = 0, acc_cyc = 0, wcount = 0;
  logic        seen = 1'b0;
  logic [31:0] first_rd;
  logic        first_err;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      ncyc++;
      if (req_valid && req_ready && !reset) begin
        acc_cyc = ncyc;
        wcount  = 0;
        seen    = 1'b0;
      end
      if (mem_we) begin
        if (sb.size() == 0) fail("unexpected_mem_we");
        else begin
          wcount++;
          check("mem_addr", mem_addr, sb[0].waddr);
          check("mem_wdata", mem_wdata, sb[0].wword);
        end
      end
      if (resp_valid) begin
        if (sb.size() == 0) fail("unexpected_resp");
        else begin
          if (!seen) begin
            seen      = 1'b1;
            first_rd  = resp_rdata;
            first_err = resp_err;
            check("latency", 32'(ncyc - acc_cyc), 32'(sb[0].lat));
          end else begin
            check("hold_rdata", resp_rdata, first_rd);
            check("hold_err", 32'(resp_err), 32'(first_err));
          end
          check("busy_ready", 32'(req_ready), 32'd0);
          if (resp_ready) begin
            check("resp_rdata", resp_rdata, sb[0].rdata);
            check("resp_err", 32'(resp_err), 32'(sb[0].err));
            check("write_count", 32'(wcount), 32'(sb[0].writes));
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int          mism;
    logic [1:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < MW; i++) ref_mem[i] = init_word(i);
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'd0;
    req_sign   = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Word store then word load.
    do_txn(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 0, 1'b0, 32'd0);
    check("sw_mem", tb_mem[4], 32'h1122_3344);
    do_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 0, 1'b1, 32'h1122_3344);
    // Byte store and byte loads.
    do_txn(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AB, 1, 1'b0, 32'd0);
    check("sb_mem", tb_mem[4], 32'h11AB_3344);
    do_txn(1'b0, 2'b00, 1'b1, 32'h12, 32'd0, 0, 1'b1, 32'hFFFF_FFAB);
    do_txn(1'b0, 2'b00, 1'b0, 32'h12, 32'd0, 0, 1'b1, 32'h0000_00AB);
    // Half store and half loads.
    do_txn(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 0, 1'b0, 32'd0);
    do_txn(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_8001, 0, 1'b0, 32'd0);
    check("sh_mem", tb_mem[4], 32'h8001_3344);
    do_txn(1'b0, 2'b01, 1'b1, 32'h12, 32'd0, 0, 1'b1, 32'hFFFF_8001);
    do_txn(1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 2, 1'b1, 32'h0000_8001);
    // Error cases: no access, immediate error response.
    do_txn(1'b0, 2'b10, 1'b0, 32'h13, 32'd0, 0, 1'b1, 32'd0);
    do_txn(1'b0, 2'b01, 1'b1, 32'h11, 32'd0, 0, 1'b1, 32'd0);
    do_txn(1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 0, 1'b1, 32'd0);
    do_txn(1'b0, 2'b10, 1'b0, 32'(MW * 4), 32'd0, 0, 1'b1, 32'd0);
    do_txn(1'b1, 2'b10, 1'b0, 32'(MW * 4), 32'hFFFF_FFFF, 0, 1'b0, 32'd0);
    do_txn(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFF_FFFF, 0, 1'b0, 32'd0);
    check("err_mem_unchanged", tb_mem[4], 32'h8001_3344);
    // Backpressure on a load response.
    do_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 5, 1'b1, 32'h8001_3344);

    // Reset during the WRITE cycle of a byte store.
    req_we    = 1'b1;
    req_size  = 2'b00;
    req_sign  = 1'b0;
    req_addr  = 32'h10;
    req_wdata = 32'h0000_00FF;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_we_gated", 32'(mem_we), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_no_resp", 32'(resp_valid), 32'd0);
    check("abort_mem", tb_mem[4], 32'h8001_3344);
    @(negedge clk);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, MW)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = $urandom;
      do_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
             $urandom_range(0, 3), 1'b0, 32'd0);
    end

    mism = 0;
    for (int i = 0; i < MW; i++) if (tb_mem[i] !== ref_mem[i]) mism++;
    check("final_mem_mismatches", 32'(mism), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, the number of 32-bit words backing the data memory; word index >= MEM_WORDS is out of range.
REQ-002 SHALL have ports: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: req_valid in 1; req_ready out 1; req_we in 1 (1=store); req_size in 2 (00 byte, 01 half, 10 word, 11 illegal); req_sign in 1 (sign-extend loads); req_addr in 32 byte address; req_wdata in 32 store data, low bits used.
REQ-005 SHALL have ports: resp_valid out 1; resp_ready in 1; resp_rdata out 32 extended load data; resp_err out 1 misaligned, illegal size or out-of-range.
REQ-006 SHALL have memory-side ports: mem_addr out 32 word-aligned byte address; mem_wdata out 32; mem_we out 1; mem_rdata in 32, combinational read of the word at mem_addr, written on the falling edge of clk while mem_we=1.

Function
REQ-007 SHALL implement FSM states IDLE, LOAD, READ, WRITE, RESP; req_ready=1 only in IDLE.
REQ-008 SHALL accept a request on a rising edge with req_valid & req_ready and latch addr, size, sign, we, wdata.
REQ-009 SHALL flag error when size=11, size=01 with addr[0]=1, size=10 with addr[1:0]!=0, or addr[31:2] >= MEM_WORDS; error requests go IDLE->RESP with resp_err=1, resp_rdata=0, and no memory access.
REQ-010 SHALL route legal requests from IDLE: load->LOAD; word store->WRITE; byte/half store->READ.
REQ-011 SHALL drive mem_addr={addr[31:2],2'b00} in LOAD, READ and WRITE, and 0 in IDLE and RESP.
REQ-012 In LOAD SHALL capture the selected lane of mem_rdata, zero- or sign-extend per req_sign to 32 bits (word loads unchanged), then go to RESP.
REQ-013 In READ SHALL capture mem_rdata, replace the addressed byte (lane addr[1:0]) or half (lane addr[1]) with wdata[7:0] or wdata[15:0], then go to WRITE.
REQ-014 SHALL use little-endian lanes: byte at offset 0 is bits 7:0, half at offset 2 is bits 31:16.
REQ-015 In WRITE SHALL assert mem_we=1 for exactly one cycle with mem_wdata = merged word (or wdata for word stores), then go to RESP; mem_we=0 and mem_wdata=0 in all other states.
REQ-016 In RESP SHALL hold resp_valid=1 with stable resp_rdata/resp_err until resp_ready=1, then return to IDLE; resp_rdata=0 for stores.
REQ-017 Latency from accept edge T to first resp_valid: error T+1, load T+2, word store T+2, byte/half store T+3.
REQ-018 SHALL not accept a new request in the cycle resp completes; the next accept is at the earliest one cycle after the RESP->IDLE edge.

Reset
REQ-019 While reset=1, the next rising edge SHALL force IDLE and clear all latched registers to 0.
REQ-020 SHALL gate mem_we with !reset combinationally so that reset asserted during WRITE suppresses the falling-edge write.
REQ-021 Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_addr=0, mem_wdata=0, mem_we=0.
REQ-022 A request aborted by reset SHALL produce no response and no memory write.

Structure
REQ-023 Package mem_acc_pkg SHALL hold the size encodings SZ_BYTE/SZ_HALF/SZ_WORD and the FSM state type.
REQ-024 A combinational sub-module mem_lane_fmt SHALL implement lane extract/extend (REQ-012) and merge (REQ-013); the top holds only the FSM and registers.

Verification
REQ-025 Word store 0x11223344 to 0x10, then load word 0x10 -> mem_we one cycle; resp_rdata=0x11223344; resp_err=0; load resp at T+2.
REQ-026 With word 0x10=0x11223344, sb 0xAB at 0x12 -> memory 0x11AB3344, resp at T+3; then lb signed at 0x12 -> 0xFFFFFFAB; lbu -> 0x000000AB.
REQ-027 sh 0x8001 at 0x12 over 0x11223344 -> 0x80013344; lh signed at 0x12 -> 0xFFFF8001; lhu -> 0x00008001.
REQ-028 lw at 0x13, lh at 0x11, size=11, lw at word index MEM_WORDS -> resp_err=1 at T+1, resp_rdata=0, mem_we never asserted, memory unchanged.
REQ-029 Hold resp_ready=0 for 5 cycles after a load -> resp_valid and resp_rdata stable; req_ready=0 throughout; IDLE after handshake.
REQ-030 Assert reset in the WRITE cycle of sb 0xFF at 0x10 -> no memory change, no resp_valid, req_ready=1 after the edge.
